// File: rtl/cyber_player.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cyber_player : LFSR-driven computer opponent emitting 1-cycle presses     |
// | Option macro : CYBER_DIV_BYPASS_EN (tick on every enabled cycle)          |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
module cyber_player #(
  parameter int         DIV_W   = 15,
  parameter int         HOLDOFF = 2,
  parameter logic [9:0] SEED    = 10'h001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [8:0] level,
  output logic       p,
  output logic [9:0] lfsr_q
);

  localparam int                c_HOLD_W   = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_INIT = c_HOLD_W'(HOLDOFF);
  localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);
  localparam logic              c_USE_HOLD = (HOLDOFF > 0);

  typedef enum logic [0:0] {
    S_ARMED = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_HOLD_W-1:0] r_hold_cnt;
  logic [c_HOLD_W-1:0] w_hold_nxt;
  logic [9:0]          r_lfsr;
  logic [9:0]          w_lfsr_nxt;
  logic                r_p;
  logic                w_fire;
  logic                w_hit;
  logic                w_tick;

`ifdef CYBER_DIV_BYPASS_EN
  assign w_tick = en;
`else
  logic [DIV_W-1:0] r_div_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (en) begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  assign w_tick = en & (&r_div_cnt);
`endif

  // XNOR taps: all-ones is the lock-up state, never reached from a legal seed
  assign w_lfsr_nxt = {r_lfsr[8:0], ~(r_lfsr[9] ^ r_lfsr[6])};
  assign w_hit      = ({1'b0, level} > r_lfsr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_ARMED;
      r_hold_cnt <= '0;
      r_lfsr     <= SEED;
      r_p        <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_p        <= w_fire;
      if (w_tick) begin
        r_lfsr <= w_lfsr_nxt;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_fire      = 1'b0;
    if (w_tick) begin
      case (r_state)
        S_ARMED: begin
          if (w_hit) begin
            w_fire = 1'b1;
            if (c_USE_HOLD) begin
              w_state_nxt = S_HOLD;
              w_hold_nxt  = c_HOLD_INIT;
            end
          end
        end
        S_HOLD: begin
          w_hold_nxt = r_hold_cnt - 1'b1;
          if (r_hold_cnt == c_HOLD_ONE) begin
            w_state_nxt = S_ARMED;
          end
        end
        default: begin
          w_state_nxt = S_ARMED;
        end
      endcase
    end
  end

  assign p      = r_p;
  assign lfsr_q = r_lfsr;

endmodule
`default_nettype wire

// File: tb/tb_cyber_player.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cyber_player : scoreboard bench for cyber_player (DIV_W=4, HOLDOFF=2)  |
// | Revision        : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_cyber_player;

  localparam int DIV_W   = 4;
  localparam int HOLDOFF = 2;
`ifdef CYBER_DIV_BYPASS_EN
  localparam int TICK = 1;
`else
  localparam int TICK = 1 << DIV_W;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [8:0] level = '0;
  logic       p;
  logic [9:0] lfsr_q;

  cyber_player #(
    .DIV_W  (DIV_W),
    .HOLDOFF(HOLDOFF),
    .SEED   (10'h001)
  ) u_dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .level (level),
    .p     (p),
    .lfsr_q(lfsr_q)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int later_pulse_k = 0;

  int         m_div;
  logic [9:0] m_lfsr;
  logic       m_armed;
  int         m_hold;
  logic       m_p;
  logic [10:0] exp_q[$];

  task automatic model_reset();
    m_div   = 0;
    m_lfsr  = 10'h001;
    m_armed = 1'b1;
    m_hold  = 0;
    m_p     = 1'b0;
    cyc     = 0;
    later_pulse_k = 0;
    exp_q.delete();
  endtask

  // One clock edge: predict, push, advance, pop and compare.
  task automatic clk_cycle();
    logic        tick;
    logic        hit;
    logic [10:0] e;
`ifdef CYBER_DIV_BYPASS_EN
    tick = en;
`else
    tick = en && (m_div == TICK - 1);
`endif
    hit = (int'(level) > int'(m_lfsr));
    m_p = 1'b0;
    if (en) m_div = (m_div + 1) % TICK;
    if (tick) begin
      if (m_armed) begin
        if (hit) begin
          m_p = 1'b1;
          m_armed = 1'b0;
          m_hold = HOLDOFF;
        end
      end else begin
        if (m_hold == 1) m_armed = 1'b1;
        m_hold = m_hold - 1;
      end
      m_lfsr = {m_lfsr[8:0], ~(m_lfsr[9] ^ m_lfsr[6])};
    end
    exp_q.push_back({m_p, m_lfsr});
    @(posedge clk);
    #1;
    cyc++;
    e = exp_q.pop_front();
    vectors++;
    if ({p, lfsr_q} !== e) begin
      miscompares++;
      $display("FAIL cycle %0d p/lfsr: got %b/%h expected %b/%h", cyc, p, lfsr_q, e[10], e[9:0]);
    end
    if (p === 1'b1 && cyc > TICK && later_pulse_k == 0) later_pulse_k = cyc;
  endtask

  // Called at posedge+1; reset must act before the next edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    vectors++;
    if (p !== 1'b0 || lfsr_q !== 10'h001) begin
      miscompares++;
      $display("FAIL %s immediate reset: got p=%b lfsr=%h expected p=0 lfsr=001", tag, p, lfsr_q);
    end
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b0;
    level = '0;
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (p !== 1'b0 || lfsr_q !== 10'h001) begin
      miscompares++;
      $display("FAIL power-on reset: got p=%b lfsr=%h expected p=0 lfsr=001", p, lfsr_q);
    end
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    en = 1'b1;
    level = 9'd300;
    repeat (3 * TICK + 2) clk_cycle();
    do_reset("mid-run");
    repeat (2 * TICK) clk_cycle();
  endtask

  task automatic test_level0();
    logic [9:0] seq [8];
    seq = '{10'h001, 10'h003, 10'h007, 10'h00F, 10'h01F, 10'h03F, 10'h07F, 10'h0FE};
    level = '0;
    en = 1'b1;
    do_reset("level0");
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (lfsr_q !== seq[i]) begin
        miscompares++;
        $display("FAIL lfsr step %0d: got %h expected %h", i, lfsr_q, seq[i]);
      end
      repeat (TICK) clk_cycle();
    end
    repeat (8 * TICK) clk_cycle();
  endtask

  task automatic test_max_level();
    int pulses;
    level = 9'd511;
    en = 1'b1;
    do_reset("max");
    pulses = 0;
    repeat (9 * TICK) begin
      clk_cycle();
      if (p === 1'b1) pulses++;
    end
    vectors++;
    if (pulses != 3) begin
      miscompares++;
      $display("FAIL max-level pulse count: got %0d expected 3", pulses);
    end
  endtask

  task automatic test_en_freeze();
    logic [9:0] held;
    level = 9'd511;
    en = 1'b1;
    do_reset("freeze");
    repeat (TICK + 1) clk_cycle();
    held = lfsr_q;
    en = 1'b0;
    repeat (5) clk_cycle();
    vectors++;
    if (lfsr_q !== held || p !== 1'b0) begin
      miscompares++;
      $display("FAIL freeze hold: got p=%b lfsr=%h expected p=0 lfsr=%h", p, lfsr_q, held);
    end
    en = 1'b1;
    repeat (3 * TICK + 4) clk_cycle();
    vectors++;
    if (later_pulse_k != 4 * TICK + 5) begin
      miscompares++;
      $display("FAIL resume timing: second press at %0d expected %0d", later_pulse_k, 4 * TICK + 5);
    end
  endtask

  task automatic test_rst_during_pulse();
    level = 9'd511;
    en = 1'b1;
    do_reset("pulse-pre");
    repeat (TICK) clk_cycle();
    vectors++;
    if (p !== 1'b1) begin
      miscompares++;
      $display("FAIL first press: got p=%b expected 1", p);
    end
    #1;
    do_reset("during-pulse");
    repeat (TICK + 2) clk_cycle();
  endtask

  task automatic test_random_level();
    level = 9'd128;
    en = 1'b1;
    do_reset("random");
    repeat (30 * TICK) begin
      level = 9'($urandom_range(0, 511));
      en = ($urandom_range(0, 7) != 0);
      clk_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_level0();
    test_max_level();
    test_en_freeze();
    test_rst_during_pulse();
    test_random_level();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
